// File: rtl/elevator_dispatcher.sv
// rtl/elevator_dispatcher.sv - SCAN elevator car controller consuming the floor request queue
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-high reset
//   queue_status    pending request bitmap from elevator_queue (bit n = floor n)
//   r_nwr           to queue: 1 = read, 0 = write (clear)
//   deassert_floor  to queue: single-cycle pulse clearing requested_floor
//   requested_floor floor index being cleared
//   current_floor   car position
//   motor_up        car moving up
//   motor_down      car moving down
//   door_open       door open
module elevator_dispatcher #(
    parameter int FLOOR_COUNT         = 7,
    parameter int FLOOR_TRAVEL_CYCLES = 50,
    parameter int DOOR_OPEN_CYCLES    = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FLOOR_COUNT-1:0] queue_status,
    output logic                   r_nwr,
    output logic                   deassert_floor,
    output logic [2:0]             requested_floor,
    output logic [2:0]             current_floor,
    output logic                   motor_up,
    output logic                   motor_down,
    output logic                   door_open
);

    localparam int TW = (FLOOR_TRAVEL_CYCLES > 1) ? $clog2(FLOOR_TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_OPEN_CYCLES > 1) ? $clog2(DOOR_OPEN_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_OPEN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVING, ARRIVE, DOOR_OPEN} state_t;

    state_t        state, state_nx;
    logic          dir, dir_nx;              // 1 = up, 0 = down
    logic [2:0]    floor_nx, step_floor;
    logic [TW-1:0] travel_cnt, travel_nx;
    logic [DW-1:0] door_cnt, door_nx;

    logic       motor_up_nx, motor_down_nx, door_open_nx;
    logic       r_nwr_nx, deassert_nx;
    logic [2:0] requested_nx;

    function automatic logic at_floor(input logic [FLOOR_COUNT-1:0] q, input logic [2:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++)
            if (q[i] && (i == int'(f))) r = 1'b1;
        return r;
    endfunction

    // Any pending request strictly beyond floor f in the given direction.
    function automatic logic pending_beyond(input logic [FLOOR_COUNT-1:0] q, input logic [2:0] f,
                                            input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++)
            if (q[i] && (up ? (i > int'(f)) : (i < int'(f)))) r = 1'b1;
        return r;
    endfunction

    // A MOVING car always has a request ahead, so the step never leaves 0..FLOOR_COUNT-1.
    assign step_floor = dir ? current_floor + 3'd1 : current_floor - 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            dir             <= 1'b1;
            current_floor   <= 3'd0;
            travel_cnt      <= '0;
            door_cnt        <= '0;
            motor_up        <= 1'b0;
            motor_down      <= 1'b0;
            door_open       <= 1'b0;
            r_nwr           <= 1'b1;
            deassert_floor  <= 1'b0;
            requested_floor <= 3'd0;
        end else begin
            state           <= state_nx;
            dir             <= dir_nx;
            current_floor   <= floor_nx;
            travel_cnt      <= travel_nx;
            door_cnt        <= door_nx;
            motor_up        <= motor_up_nx;
            motor_down      <= motor_down_nx;
            door_open       <= door_open_nx;
            r_nwr           <= r_nwr_nx;
            deassert_floor  <= deassert_nx;
            requested_floor <= requested_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        dir_nx    = dir;
        floor_nx  = current_floor;
        travel_nx = travel_cnt;
        door_nx   = door_cnt;
        case (state)
            IDLE: begin
                if (at_floor(queue_status, current_floor)) begin
                    state_nx = ARRIVE;
                end else if (pending_beyond(queue_status, current_floor, dir)) begin
                    state_nx  = MOVING;
                    travel_nx = '0;
                end else if (pending_beyond(queue_status, current_floor, !dir)) begin
                    state_nx  = MOVING;
                    dir_nx    = !dir;
                    travel_nx = '0;
                end
            end
            MOVING: begin
                if (travel_cnt == TRAVEL_LAST) begin
                    travel_nx = '0;
                    floor_nx  = step_floor;
                    if (at_floor(queue_status, step_floor))
                        state_nx = ARRIVE;
                    else if (!pending_beyond(queue_status, step_floor, dir))
                        state_nx = IDLE;
                end else begin
                    travel_nx = travel_cnt + TW'(1);
                end
            end
            ARRIVE: begin
                state_nx = DOOR_OPEN;
                door_nx  = '0;
            end
            DOOR_OPEN: begin
                // First door cycle ignores the floor bit: our own clear has not landed yet.
                if ((door_cnt != '0) && at_floor(queue_status, current_floor)) begin
                    state_nx = ARRIVE;
                end else if (door_cnt == DOOR_LAST) begin
                    state_nx = IDLE;
                    door_nx  = '0;
                end else begin
                    door_nx = door_cnt + DW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output values for the next cycle, registered alongside the state.
    always_comb begin
        motor_up_nx   = (state_nx == MOVING) && dir_nx;
        motor_down_nx = (state_nx == MOVING) && !dir_nx;
        deassert_nx   = (state_nx == ARRIVE);
        r_nwr_nx      = (state_nx != ARRIVE);
        requested_nx  = (state_nx == ARRIVE) ? floor_nx : requested_floor;
        // A re-press while the door is open keeps the door open through the clear cycle.
        door_open_nx  = (state_nx == DOOR_OPEN) || ((state_nx == ARRIVE) && door_open);
    end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// tb/tb_elevator_dispatcher.sv - directed self-checking bench for elevator_dispatcher
module tb_elevator_dispatcher;

    localparam int FC = 7;
    localparam int SIG_MU = 0, SIG_MD = 1, SIG_DO = 2, SIG_DA = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [FC-1:0] q = '0;
    logic [FC-1:0] press;
    logic [FC-1:0] clr;
    logic          r_nwr, deassert_floor, motor_up, motor_down, door_open;
    logic [2:0]    requested_floor, current_floor;
    logic          prev_da = 1'b0;
    int            checks = 0;
    int            errors = 0;

    elevator_dispatcher #(
        .FLOOR_COUNT(FC), .FLOOR_TRAVEL_CYCLES(4), .DOOR_OPEN_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .queue_status(q), .r_nwr(r_nwr),
        .deassert_floor(deassert_floor), .requested_floor(requested_floor),
        .current_floor(current_floor), .motor_up(motor_up), .motor_down(motor_down),
        .door_open(door_open)
    );

    always #5 clk = ~clk;

    // Request queue model: panel presses set bits, the dispatcher's write pulse clears one.
    always_comb clr = (deassert_floor && !r_nwr) ? (FC'(1) << requested_floor) : '0;
    always @(posedge clk) q <= (q & ~clr) | press;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("motors_both", int'(motor_up & motor_down), 0);
        check("door_with_motor", int'(door_open & (motor_up | motor_down)), 0);
        check("deassert_twice", int'(deassert_floor & prev_da), 0);
        check("rnwr_without_deassert", int'(!r_nwr & !deassert_floor), 0);
        prev_da <= deassert_floor;
    end

    function automatic logic sig(input int s);
        case (s)
            SIG_MU:  return motor_up;
            SIG_MD:  return motor_down;
            SIG_DO:  return door_open;
            default: return deassert_floor;
        endcase
    endfunction

    task automatic do_press(input logic [FC-1:0] m);
        press = m;
        @(negedge clk);
        press = '0;
    endtask

    task automatic wait_high(input int s, input string tag);
        int k;
        k = 0;
        while (!sig(s) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(sig(s)), 1);
    endtask

    task automatic count_high(input int s, output int n, output int mid);
        n = 0;
        mid = -1;
        while (sig(s) && n < 400) begin
            if (n == 4) mid = int'(current_floor);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic travel(input int s, input int cycles, input int exp_mid, input string tag);
        int n, mid;
        wait_high(s, {tag, "_start"});
        count_high(s, n, mid);
        check({tag, "_cycles"}, n, cycles);
        if (exp_mid >= 0) check({tag, "_mid_floor"}, mid, exp_mid);
    endtask

    task automatic arrive_check(input int f, input string tag);
        int n, mid;
        wait_high(SIG_DA, {tag, "_clear"});
        check({tag, "_req_floor"}, int'(requested_floor), f);
        check({tag, "_cur_floor"}, int'(current_floor), f);
        check({tag, "_rnwr"}, int'(r_nwr), 0);
        check({tag, "_door_at_clear"}, int'(door_open), 0);
        wait_high(SIG_DO, {tag, "_door"});
        count_high(SIG_DO, n, mid);
        check({tag, "_door_cycles"}, n, 3);
        check({tag, "_queue_cleared"}, int'(q[f]), 0);
        check({tag, "_idle_motors"}, int'(motor_up | motor_down), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_floor"}, int'(current_floor), 0);
        check({tag, "_mu"}, int'(motor_up), 0);
        check({tag, "_md"}, int'(motor_down), 0);
        check({tag, "_door"}, int'(door_open), 0);
        check({tag, "_rnwr"}, int'(r_nwr), 1);
        check({tag, "_da"}, int'(deassert_floor), 0);
        check({tag, "_req"}, int'(requested_floor), 0);
    endtask

    initial begin
        int n, pulses;
        reset = 1'b1;
        press = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // Request at the floor the car is idling on: clear immediately, no motion.
        do_press(7'b0000001);
        arrive_check(0, "t2");

        // Single request two floors up.
        do_press(7'b0000100);
        travel(SIG_MU, 8, 1, "t1_up");
        arrive_check(2, "t1");

        // Up one floor to 3, then a request behind flips the direction.
        do_press(7'b0001000);
        travel(SIG_MU, 4, -1, "t3_up");
        arrive_check(3, "t3a");
        do_press(7'b0000010);
        travel(SIG_MD, 8, 2, "t3_down");
        arrive_check(1, "t3");

        // Reset while travelling up from floor 1 with the travel counter at 2.
        do_press(7'b0010000);
        wait_high(SIG_MU, "t6_start");
        repeat (2) @(negedge clk);
        check("t6_floor_before", int'(current_floor), 1);
        reset = 1'b1;
        #1;
        check_reset_vals("t6_async");
        @(negedge clk);
        reset = 1'b0;
        check("t6_floor_released", int'(current_floor), 0);
        travel(SIG_MU, 16, 1, "t6_up");
        arrive_check(4, "t6");

        // SCAN from floor 0 with floors 2 and 5 pending, re-press of 2 while the door is open.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_press(7'b0100100);
        travel(SIG_MU, 8, 1, "t4_up2");
        wait_high(SIG_DA, "t4_clear2");
        check("t4_req2", int'(requested_floor), 2);
        wait_high(SIG_DO, "t5_door");
        n = 1;
        pulses = 0;
        do_press(7'b0000100);
        while (door_open && n < 50) begin
            n++;
            if (deassert_floor) begin
                pulses++;
                check("t5_req_repress", int'(requested_floor), 2);
            end
            @(negedge clk);
        end
        check("t5_door_cycles", n, 6);
        check("t5_clear_pulses", pulses, 1);
        check("t5_queue", int'(q), 32);
        travel(SIG_MU, 12, 3, "t4_up5");
        arrive_check(5, "t4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
